f1_start_seq: RTL

- Start-light sequencer that consumes the 8-bit pseudo-random value produced by the lab's LFSR stage.
- On a trigger, it lights N_LIGHTS lamps one per tick. It then holds all lamps on for a random number of ticks taken from the LFSR, turns all lamps off and pulses `go`.
- It then measures reaction time in clock cycles until `stop` is pressed, and flags a jump start if `stop` arrives early.
- It also drives the LFSR's enable, so the LFSR free-runs only while idle.

---
 rtl/f1_start_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/f1_start_seq.sv
// Start-light sequencer: lamps fill one per tick, hold for a random LFSR-derived delay,
// then go out with a go pulse; the driver's reaction time is measured in clk cycles.
module f1_start_seq #(
  parameter int                N_LIGHTS   = 8,
  parameter int                RND_W      = 8,
  parameter logic [RND_W-1:0]  DELAY_MASK = 8'h1F,
  parameter int                RT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger,
  input  logic                tick,
  input  logic                stop,
  input  logic [RND_W-1:0]    rnd_in,
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] lights,
  output logic                go,
  output logic                busy,
  output logic [RT_W-1:0]     rt_value,
  output logic                rt_valid,
  output logic                jump_start
);

  typedef enum logic [1:0] {S_IDLE, S_LIGHTS, S_HOLD, S_REACT} state_t;

  localparam logic [RND_W-1:0] DLY_ONE = RND_W'(1);

  state_t                state_q, state_d;
  logic [N_LIGHTS-1:0]   lights_q, lights_d;
  logic                  go_q, go_d;
  logic [RT_W-1:0]       rt_value_q, rt_value_d;
  logic                  rt_valid_q, rt_valid_d;
  logic                  jump_q, jump_d;
  logic [RND_W-1:0]      dly_q, dly_d;
  logic [RT_W-1:0]       rt_cnt_q, rt_cnt_d;
  logic                  jump_ev;

  function automatic logic [RT_W-1:0] sat_inc(input logic [RT_W-1:0] v);
    return (&v) ? v : v + RT_W'(1);
  endfunction

  // A masked value of zero would mean no hold at all, so it is promoted to one tick.
  function automatic logic [RND_W-1:0] delay_sel(input logic [RND_W-1:0] r);
    logic [RND_W-1:0] m;
    m = r & DELAY_MASK;
    return (m == '0) ? DLY_ONE : m;
  endfunction

  // Early stop: during the light-up, the hold, or the very cycle go is showing.
  assign jump_ev = stop && ((state_q == S_LIGHTS) || (state_q == S_HOLD) ||
                            ((state_q == S_REACT) && go_q));

  always_comb begin
    state_d    = state_q;
    lights_d   = lights_q;
    go_d       = 1'b0;
    rt_value_d = rt_value_q;
    rt_valid_d = 1'b0;
    jump_d     = jump_q;
    dly_d      = dly_q;
    rt_cnt_d   = rt_cnt_q;

    if (jump_ev) begin
      jump_d   = 1'b1;
      lights_d = '0;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            lights_d = '0;
            jump_d   = 1'b0;
            state_d  = S_LIGHTS;
          end
        end
        S_LIGHTS: begin
          if (tick) begin
            lights_d = {lights_q[N_LIGHTS-2:0], 1'b1};
            if (&lights_q[N_LIGHTS-2:0]) begin
              dly_d   = delay_sel(rnd_in);
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            dly_d = dly_q - DLY_ONE;
            if (dly_q == DLY_ONE) begin
              lights_d = '0;
              go_d     = 1'b1;
              rt_cnt_d = '0;
              state_d  = S_REACT;
            end
          end
        end
        S_REACT: begin
          if (stop) begin
            rt_value_d = rt_cnt_q;
            rt_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            rt_cnt_d = sat_inc(rt_cnt_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lights_q   <= '0;
      go_q       <= 1'b0;
      rt_value_q <= '0;
      rt_valid_q <= 1'b0;
      jump_q     <= 1'b0;
      dly_q      <= '0;
      rt_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      lights_q   <= lights_d;
      go_q       <= go_d;
      rt_value_q <= rt_value_d;
      rt_valid_q <= rt_valid_d;
      jump_q     <= jump_d;
      dly_q      <= dly_d;
      rt_cnt_q   <= rt_cnt_d;
    end
  end

  assign lfsr_en    = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign lights     = lights_q;
  assign go         = go_q;
  assign rt_value   = rt_value_q;
  assign rt_valid   = rt_valid_q;
  assign jump_start = jump_q;

endmodule
